// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and holds
// the instruction until retire. Optional jump-register support under `FETCH_JR_EN`.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    input  logic        advance,
`ifdef FETCH_JR_EN
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        fetch_err,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] pcplus4_s;
    logic [31:0] next_pc_s;
`ifdef FETCH_JR_EN
    logic        fetch_err_q, fetch_err_d;
`endif

    function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pcp4, input logic [31:0] imm);
        return pcp4 + (imm << 2);
    endfunction

    assign pcplus4_s = pc_q + 32'd4;

    // Next-PC selection; only consumed on a retire cycle.
    always_comb begin
        next_pc_s = pcplus4_s;
`ifdef FETCH_JR_EN
        if (jr) begin
            next_pc_s = jr_target & ~32'h0000_0003;
        end else if (jump) begin
            next_pc_s = jump_target(pcplus4_s[31:28], instr_q[25:0]);
        end else if (pcsrc) begin
            next_pc_s = branch_target(pcplus4_s, signimm);
        end else begin
            next_pc_s = pcplus4_s;
        end
`else
        if (jump) begin
            next_pc_s = jump_target(pcplus4_s[31:28], instr_q[25:0]);
        end else if (pcsrc) begin
            next_pc_s = branch_target(pcplus4_s, signimm);
        end else begin
            next_pc_s = pcplus4_s;
        end
`endif
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
`ifdef FETCH_JR_EN
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    pc_d      = next_pc_s;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
`ifdef FETCH_JR_EN
                    if (jr && (jr_target[1:0] != 2'b00)) begin
                        fetch_err_d = 1'b1;
                    end else begin
                        fetch_err_d = fetch_err_q;
                    end
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
        // Handshake flags are registered from the next state so they are glitch-free.
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_EXEC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RST;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
`ifdef FETCH_JR_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
`ifdef FETCH_JR_EN
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pcplus4     = pcplus4_s;
    assign retired     = retired_q;
`ifdef FETCH_JR_EN
    assign fetch_err   = fetch_err_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle MIPS core, directly downstream of the controller. Consumes `pcsrc` and `jump` together with the sign-extended immediate. Owns the program counter and fetches each instruction through a request/acknowledge handshake with instruction memory. Presents a held instruction to decode until the datapath retires it.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pcsrc` in 1: branch taken (`branch & zero`); sampled only on a retire cycle.
- `jump` in 1: jump instruction; sampled only on a retire cycle.
- `signimm` in 32: sign-extended 16-bit immediate of the current instruction.
- `advance` in 1: datapath retires the current instruction this cycle.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory returns data this cycle; meaningful only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`=1.
- `instr` out 32: held instruction for decode (`op`=`[31:26]`, `funct`=`[5:0]`).
- `instr_valid` out 1: `instr` is valid and awaiting retire.
- `pc` out 32: address of the current instruction.
- `pcplus4` out 32: `pc + 4`, combinational.
- `retired` out 32: count of retired instructions, wrapping.

## Operation
- The FSM has three states: `RST`, `FETCH` and `EXEC`.
- `RST`: entered while `reset_n`=0. On the first edge after release, go to `FETCH`.
- `FETCH`: `imem_req`=1 and `imem_addr`=`pc`, held stable until ack. When `imem_ack`=1, latch `instr`<=`imem_rdata` and go to `EXEC`. Otherwise stay in `FETCH`.
- `EXEC`: `instr_valid`=1. When `advance`=1, update `pc`<=next PC, increment `retired`, and go to `FETCH`. Otherwise hold `pc` and `instr`.
- Next PC, evaluated only on a retire cycle. Priority is jr (if compiled in) > `jump` > `pcsrc` > sequential:
  - jump target = `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - branch target = `pcplus4 + (signimm << 2)`, modulo 2^32.
  - sequential = `pcplus4`.
- Width and arithmetic: all PC arithmetic is 32-bit unsigned and wraps. `pc = 32'hFFFF_FFFC` sequential gives `32'h0000_0000`.
- Ignored inputs:
  - `advance` outside `EXEC` has no effect.
  - `imem_ack` outside `FETCH` has no effect.
  - `pcsrc`, `jump` and `signimm` have no effect outside a retire cycle.
- `pcsrc`=1 and `jump`=1 together: the jump wins.

## Timing
- Reset values: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `pcplus4`=`RESET_PC+4`, `instr`=0, `instr_valid`=0, `imem_req`=0, `retired`=0.
- First cycle after reset release: `imem_req` is still 0 (state `RST`). `imem_req`=1 from the second cycle.
- Ack in the same cycle as the request: `instr_valid`=1 on the next cycle. Minimum throughput is 2 cycles per instruction (1 `FETCH` + 1 `EXEC`).
- Per-instruction latency is 1 + (fetch wait cycles) + (`EXEC` cycles until `advance`).
- `pc` updates on the retire edge. The new `imem_req` is asserted in the following cycle with the new address.
- Reset asserted mid-fetch or mid-execute: all outputs immediately return to their reset values (asynchronous). The pending request is abandoned and no retire is counted.

## Configuration
- Macro `FETCH_JR_EN`.
- Defined: adds the following ports, and jr becomes the highest next-PC priority.
  - `jr` in 1: jump-register instruction.
  - `jr_target` in 32: register value used as the next PC.
  - `fetch_err` out 1: sticky, reset 0. Sets when a retire with `jr`=1 supplies `jr_target[1:0]`≠0. The PC still loads `jr_target & ~32'h3`.
- Undefined: these ports do not exist and next-PC priority is `jump` > `pcsrc` > sequential.

## Test plan
- Reset, `RESET_PC`=`32'h0000_0040`, memory acks with 0 wait: first `imem_req`=1 with `imem_addr`=`0x40` on the 2nd cycle after release. With `advance` always 1, addresses are `0x40`, `0x44`, `0x48`, and `retired` reaches 3 after six active cycles.
- `pc`=`0x100`, `pcsrc`=1, `signimm`=`32'hFFFF_FFFE`, `advance`=1: next `imem_addr`=`0xFC`. Same setup with `pcsrc`=0: next `imem_addr`=`0x104`.
- `pc`=`0x1000_0000`, `instr[25:0]`=`26'h0000010`, `jump`=1 and `pcsrc`=1: next `imem_addr`=`0x1000_0040` (jump wins).
- Memory delays `imem_ack` by 3 cycles: `imem_addr` stays stable and `instr_valid` stays 0 throughout. `instr`=`imem_rdata` one cycle after the ack. `advance` pulses during the wait are ignored and `retired` is unchanged.
- `reset_n` pulsed low while in `EXEC` with `retired`=5: `instr_valid`=0, `imem_req`=0, `retired`=0 and `pc`=`RESET_PC` without waiting for a clock edge.
- With `FETCH_JR_EN`: a retire with `jr`=1 and `jr_target`=`0x202`. The next `imem_addr`=`0x200` and `fetch_err` is 1 until reset.
